keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/sync2.sv | 24 ++
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key mapping for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2
    } state_t;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Physical layout: rows top to bottom, columns left to right.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'd0;
        case ({r, c})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_A;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_B;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            4'hF: code = KEY_D;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Lowest set row wins when several keys in one column are down.
    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make both flops sample the old values, forming a true two-stage chain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and single-cycle keystrobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       keystrobe,
    output logic [3:0] keycode
);

    localparam int MAX_AB = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int MAX_CD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX   = '1;
    localparam cnt_t SCAN_LAST = cnt_t'(SCAN_DIV - 1);
    localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

    logic [3:0] srow;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (row),
        .q    (srow)
    );

    state_t     state_q, state_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [1:0] row_sel_q, row_sel_d;
    cnt_t       scan_cnt_q, scan_cnt_d;
    cnt_t       deb_cnt_q, deb_cnt_d;
    logic [3:0] keycode_q, keycode_d;
    logic       strobe_q, strobe_d;
    logic       hit;

`ifdef KEYPAD_REPEAT_EN
    localparam cnt_t REP_FIRST_LAST = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t REP_NEXT_LAST  = cnt_t'(REPEAT_PERIOD - 1);
    cnt_t rep_cnt_q, rep_cnt_d;
    logic rep_first_q, rep_first_d;
`endif

    assign hit = srow[row_sel_q];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        row_sel_d  = row_sel_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        keycode_d  = keycode_q;
        strobe_d   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (srow != 4'd0) begin
                        row_sel_d = lowest_row(srow);
                        deb_cnt_d = '0;
                        state_d   = DEB_PRESS;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = sat_inc(scan_cnt_q);
                end
            end
            DEB_PRESS: begin
                if (!hit) begin
                    state_d    = SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    scan_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    strobe_d  = 1'b1;
                    keycode_d = keymap(row_sel_q, col_idx_q);
                    deb_cnt_d = '0;
                    state_d   = HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    deb_cnt_d = sat_inc(deb_cnt_q);
                end
            end
            HELD: begin
                if (hit) begin
                    deb_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                    if (rep_cnt_q == (rep_first_q ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
                        strobe_d    = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = sat_inc(rep_cnt_q);
                    end
`endif
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    // Any release activity restarts the repeat schedule from the long delay.
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d    = SCAN;
                        col_idx_d  = col_idx_q + 2'd1;
                        scan_cnt_d = '0;
                        deb_cnt_d  = '0;
                    end else begin
                        deb_cnt_d = sat_inc(deb_cnt_q);
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            row_sel_q  <= 2'd0;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            keycode_q  <= 4'd0;
            strobe_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            row_sel_q  <= row_sel_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            keycode_q  <= keycode_d;
            strobe_q   <= strobe_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign col       = 4'b0001 << col_idx_q;
    assign keystrobe = strobe_q;
    assign keycode   = keycode_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from col, a monitor checks strobes.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int RDLY     = 40;
    localparam int RPER     = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam int LONG_HOLD = 45;
    localparam int HOLD_MAX  = 45;
`else
    localparam int LONG_HOLD = 200;
    localparam int HOLD_MAX  = 120;
`endif

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       keystrobe;
    logic [3:0] keycode;
    logic [15:0] keys = '0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] col;
    } exp_t;

    exp_t sb[$];
    int   strobe_times[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   keymap_tbl[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Physical keypad: a row reads high when a pressed key sits in the driven column.
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) row[r] = |(keys[r*4 +: 4] & col);
    end

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .row       (row),
        .col       (col),
        .keystrobe (keystrobe),
        .keycode   (keycode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_key(input int r, input int c);
        exp_t e;
        e.code = 4'(keymap_tbl[r*4 + c]);
        e.col  = 4'(1 << c);
        sb.push_back(e);
    endtask

    task automatic wait_col(input logic [3:0] target, input bit want_equal, input string name);
        int n;
        n = 0;
        while (((col == target) != want_equal) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check(name, 32'(col), 32'(target));
    endtask

    // Monitor: pops the scoreboard on every strobe and watches keycode stability otherwise.
    logic [3:0] last_code   = 4'd0;
    logic       prev_strobe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!nrst) begin
            last_code   = 4'd0;
            prev_strobe = 1'b0;
        end else begin
            if (keystrobe) begin
                check("no_back_to_back", 32'(prev_strobe), 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got keycode %0d expected no strobe", keycode);
                end else begin
                    e = sb.pop_front();
                    check("strobe_keycode", 32'(keycode), 32'(e.code));
                    check("strobe_col_frozen", 32'(col), 32'(e.col));
                end
                last_code = keycode;
                strobe_times.push_back(cyc);
            end else begin
                check("keycode_hold", 32'(keycode), 32'(last_code));
            end
            prev_strobe = keystrobe;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and free-running column rotation.
        keys = '0;
        nrst = 1'b0;
        idle(3);
        check("rst_col", 32'(col), 32'd1);
        check("rst_keystrobe", 32'(keystrobe), 32'd0);
        check("rst_keycode", 32'(keycode), 32'd0);
        nrst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("rotate_col", 32'(col), 32'(1 << ((k / SCAN_DIV) % 4)));
        end

        // Key '8' held, then released: keycode must stay 8.
        expect_key(2, 1);
        keys[2*4 + 1] = 1'b1;
        idle(60);
        keys = '0;
        idle(30);
        check("keycode_held_8", 32'(keycode), 32'd8);

        // A 5-cycle bounce on row 3 while column 1 is driven: no strobe, scan resumes at column 2.
        wait_col(4'b0010, 1'b0, "wait_leave_col1");
        wait_col(4'b0010, 1'b1, "wait_enter_col1");
        keys[3*4 + 1] = 1'b1;
        idle(5);
        keys = '0;
        wait_col(4'b0010, 1'b0, "wait_bounce_exit");
        check("bounce_resume_col", 32'(col), 32'b0100);
        idle(20);

        // '#' held long, then pressed again.
        expect_key(3, 2);
        keys[3*4 + 2] = 1'b1;
        idle(LONG_HOLD);
        keys = '0;
        idle(30);
        check("keycode_hash", 32'(keycode), 32'd15);
        expect_key(3, 2);
        keys[3*4 + 2] = 1'b1;
        idle(45);
        keys = '0;
        idle(30);

        // Keys '1' and '7' together in column 0: lowest row wins.
        expect_key(0, 0);
        keys[0*4 + 0] = 1'b1;
        keys[2*4 + 0] = 1'b1;
        idle(45);
        keys = '0;
        idle(30);
        check("multi_press_code", 32'(keycode), 32'd1);

        // Reset pulse during press debounce of '5': no strobe, scanning restarts at column 0.
        keys[1*4 + 1] = 1'b1;
        nrst = 1'b0;
        idle(2);
        nrst = 1'b1;
        idle(11);
        nrst = 1'b0;
        #1;
        check("abort_col", 32'(col), 32'd1);
        check("abort_keystrobe", 32'(keystrobe), 32'd0);
        check("abort_keycode", 32'(keycode), 32'd0);
        keys = '0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("abort_restart_col", 32'(col), 32'd1);
        idle(20);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat: confirm, then +RDLY, then every RPER while held.
        begin
            int n;
            for (int i = 0; i < 5; i++) expect_key(1, 1);
            strobe_times.delete();
            keys[1*4 + 1] = 1'b1;
            n = 0;
            while (strobe_times.size() == 0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            idle(93);
            keys = '0;
            idle(30);
            check("repeat_count", 32'(strobe_times.size()), 32'd5);
            if (strobe_times.size() == 5) begin
                for (int i = 1; i < 5; i++)
                    check("repeat_interval", 32'(strobe_times[i] - strobe_times[i-1]),
                          32'((i == 1) ? RDLY : RPER));
            end
        end
`endif

        // Random single presses and short bounces.
        for (int i = 0; i < 30; i++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                keys[r*4 + c] = 1'b1;
                idle(int'($urandom_range(1, 5)));
            end else begin
                expect_key(r, c);
                keys[r*4 + c] = 1'b1;
                idle(int'($urandom_range(40, HOLD_MAX)));
            end
            keys = '0;
            idle(int'($urandom_range(20, 50)));
        end

        idle(40);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
